pdm_rx_core: RTL and testbench

Audio capture core: drives the PDM clock of an external 1-bit microphone, decimates the PDM bit stream to 16-bit signed PCM with a 3rd-order CIC filter, and buffers samples in a 16-entry FIFO. It is the receive counterpart of the synthesizer/1-bit DAC output path. It sits in an MMIO slot and also exposes the PCM stream directly for hardware routing, such as loopback into the synthesizer.

---
 rtl/pdm_rx_pkg.sv | 47 ++++
 rtl/pdm_rx_cic.sv | 77 +++++++
 rtl/pdm_rx_core.sv | 175 +++++++++++++++++
 tb/tb_pdm_rx_core.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_rx_pkg.sv
// ---------------------------------------------------------------------------
// pdm_rx_pkg: shared constants and PCM scaling helper for pdm_rx_core. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pdm_rx_pkg;

  localparam int R         = 64;
  localparam int CIC_N     = 3;
  localparam int CIC_W     = 1 + CIC_N * $clog2(R);
  localparam int PCM_W     = 16;
  localparam int PCM_SHIFT = CIC_W - 1 - PCM_W;

  // Read map; control writes share slot 01 with the count readback.
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_CNT     = 2'd1;
  localparam logic [1:0] ADDR_DVSR    = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;
  localparam logic [1:0] ADDR_CTRL_WR = 2'd1;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  localparam logic [7:0] DVSR_RST = 8'd24;

  localparam logic [CIC_W:0]        CIC_MID = (CIC_W + 1)'(R * R * R / 2);
  localparam logic signed [CIC_W:0] PCM_HI  = (CIC_W + 1)'(32767);
  localparam logic signed [CIC_W:0] PCM_LO  = (CIC_W + 1)'(-32768);

  // Re-centre the unsigned comb output around zero, scale and clamp.
  function automatic logic [PCM_W-1:0] cic_to_pcm(input logic [CIC_W-1:0] y);
    logic signed [CIC_W:0] diff;
    logic signed [CIC_W:0] shifted;
    diff    = $signed({1'b0, y} - CIC_MID);
    shifted = diff >>> PCM_SHIFT;
    if (shifted > PCM_HI) begin
      cic_to_pcm = PCM_HI[PCM_W-1:0];
    end else if (shifted < PCM_LO) begin
      cic_to_pcm = PCM_LO[PCM_W-1:0];
    end else begin
      cic_to_pcm = shifted[PCM_W-1:0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/pdm_rx_cic.sv
// ---------------------------------------------------------------------------
// cic_decim: 3rd-order CIC decimator with window and settling counters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cic_decim
  import pdm_rx_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_tick,
  input  logic             in_bit,
  output logic [CIC_W-1:0] y,
  output logic             y_valid
);

  localparam int WIN_W = $clog2(R);

  logic [CIC_W-1:0] integ1, integ2, integ3;
  logic [CIC_W-1:0] dly1, dly2, dly3;
  logic [CIC_W-1:0] comb1, comb2, comb3;
  logic [WIN_W-1:0] win_cnt;
  logic [1:0]       settle_cnt;
  logic             win_end;
  logic             settled;

  assign win_end = in_tick && (win_cnt == WIN_W'(R - 1));
  assign settled = (settle_cnt == 2'(CIC_N));

  // Combs run once per window on the integrator tail; result is presented
  // combinationally in the cycle that takes the last sample of the window.
  assign comb1 = integ3 - dly1;
  assign comb2 = comb1 - dly2;
  assign comb3 = comb2 - dly3;

  assign y       = comb3;
  assign y_valid = win_end && settled && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      integ1     <= '0;
      integ2     <= '0;
      integ3     <= '0;
      dly1       <= '0;
      dly2       <= '0;
      dly3       <= '0;
      win_cnt    <= '0;
      settle_cnt <= '0;
    end else if (clear) begin
      integ1     <= '0;
      integ2     <= '0;
      integ3     <= '0;
      dly1       <= '0;
      dly2       <= '0;
      dly3       <= '0;
      win_cnt    <= '0;
      settle_cnt <= '0;
    end else if (in_tick) begin
      integ1  <= integ1 + CIC_W'(in_bit);
      integ2  <= integ2 + integ1;
      integ3  <= integ3 + integ2;
      win_cnt <= win_cnt + WIN_W'(1);
      if (win_end) begin
        dly1 <= integ3;
        dly2 <= comb1;
        dly3 <= comb2;
        if (!settled) begin
          settle_cnt <= settle_cnt + 2'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pdm_rx_core.sv
// ---------------------------------------------------------------------------
// pdm_rx_core: PDM mic clocking, CIC decimation to PCM, sample FIFO, MMIO. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pdm_rx_core
  import pdm_rx_pkg::*;
#(
  parameter int DEPTH = 16
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        pdm_in,
  output logic        pdm_clk,
  output logic [15:0] pcm_out,
  output logic        pcm_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             enable;
  logic [7:0]       dvsr;
  logic [7:0]       div_cnt;
  logic             sync1, sync2;
  logic             tick;
  logic [CIC_W-1:0] cic_y;
  logic             cic_valid;

  logic             wr_en, pop_wr, ctrl_wr, dvsr_wr, flush;
  logic             unused_ok;

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             empty, full;
  logic             do_push, do_pop;
  logic [15:0]      head;

  assign wr_en   = cs && write;
  assign pop_wr  = wr_en && (addr[1:0] == ADDR_DATA);
  assign ctrl_wr = wr_en && (addr[1:0] == ADDR_CTRL_WR);
  assign dvsr_wr = wr_en && (addr[1:0] == ADDR_DVSR);
  assign flush   = ctrl_wr && wr_data[CTRL_FLUSH_BIT];

  assign unused_ok = ^{read, addr[4:2], wr_data[31:8]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable <= 1'b0;
      dvsr   <= DVSR_RST;
    end else begin
      if (ctrl_wr) begin
        enable <= wr_data[CTRL_EN_BIT];
      end
      if (dvsr_wr) begin
        dvsr <= wr_data[7:0];
      end
    end
  end

  // Down-counter reloads from dvsr only at a toggle, so a dvsr write lands
  // on the next half-period rather than mid-count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (div_cnt == 8'd0) begin
      div_cnt <= dvsr;
      pdm_clk <= ~pdm_clk;
    end else begin
      div_cnt <= div_cnt - 8'd1;
    end
  end

  assign tick = enable && (div_cnt == 8'd0) && pdm_clk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pdm_in;
      sync2 <= sync1;
    end
  end

  cic_decim u_cic (
    .clk     (clk),
    .reset   (reset),
    .clear   (!enable),
    .in_tick (tick),
    .in_bit  (sync2),
    .y       (cic_y),
    .y_valid (cic_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= cic_valid;
      if (cic_valid) begin
        pcm_out <= cic_to_pcm(cic_y);
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop_wr && !empty;
  assign do_push = pcm_valid && (!full || do_pop);
  assign head    = empty ? 16'h0000 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CNT_W'(1);
      end
      if (pcm_valid && full && !do_pop) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= pcm_out;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr[1:0])
      ADDR_DATA: rd_data = {14'b0, ovf, empty, head};
      ADDR_CNT:  rd_data = 32'(count);
      ADDR_DVSR: rd_data = {24'b0, dvsr};
      ADDR_CTRL: rd_data = {31'b0, enable};
      default:   rd_data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_pdm_rx_core.sv
// ---------------------------------------------------------------------------
// tb_pdm_rx_core: directed self-checking bench for pdm_rx_core. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pdm_rx_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        pdm_in = 1'b0;
  logic        pdm_clk;
  logic [15:0] pcm_out;
  logic        pcm_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pdm_rx_core #(.DEPTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .read      (read),
    .write     (write),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .pdm_in    (pdm_in),
    .pdm_clk   (pdm_clk),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid)
  );

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = {3'b000, a}; wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cs = 1'b1; read = 1'b1; addr = {3'b000, a};
    #1;
    d = rd_data;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      @(negedge clk);
      n++;
      if (pcm_valid) ok = 1'b1;
    end
  endtask

  task automatic measure_period(output int p);
    logic prev;
    bit   found;
    p = -1;
    found = 1'b0;
    prev = pdm_clk;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (!prev && pdm_clk) found = 1'b1;
      prev = pdm_clk;
    end
    if (found) begin
      found = 1'b0;
      for (int i = 1; i <= 100 && !found; i++) begin
        @(negedge clk);
        if (!prev && pdm_clk) begin
          found = 1'b1;
          p = i;
        end
        prev = pdm_clk;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pdm_in = ~pdm_in;
      checks++;
      if (pdm_clk !== 1'b0 || pcm_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs pdm_clk=%b pcm_valid=%b required 0/0", pdm_clk, pcm_valid);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    pdm_in = 1'b0;
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0001_0000) begin
      failures++; $display("FAIL reset_rd00 got=%h required=%h", d, 32'h0001_0000);
    end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL reset_rd01 got=%h required=%h", d, 32'h0);
    end
    rd(2'd2, d);
    checks++;
    if (d !== 32'd24) begin
      failures++; $display("FAIL reset_rd10 got=%h required=%h", d, 32'd24);
    end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL reset_rd11 got=%h required=%h", d, 32'h0);
    end
    checks++;
    if (pcm_out !== 16'h0000) begin
      failures++; $display("FAIL reset_pcm_out got=%h required=0000", pcm_out);
    end
  endtask

  task automatic test_divider();
    int p;
    bit bad;
    wr(2'd2, 32'd0);
    wr(2'd1, 32'd1);
    measure_period(p);
    checks++;
    if (p != 2) begin
      failures++; $display("FAIL period_dvsr0 got=%0d required=2", p);
    end
    wr(2'd2, 32'd1);
    repeat (6) @(negedge clk);
    measure_period(p);
    checks++;
    if (p != 4) begin
      failures++; $display("FAIL period_dvsr1 got=%0d required=4", p);
    end
    wr(2'd1, 32'd0);
    @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pdm_clk !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL disabled_pdm_clk got=toggling required=held 0");
    end
  endtask

  task automatic test_ones();
    int n;
    bit ok;
    pdm_in = 1'b1;
    wr(2'd1, 32'd1);
    wait_valid(1100, n, ok);
    checks++;
    if (!ok || n != 1024) begin
      failures++; $display("FAIL first_valid_latency got=%0d ok=%0d required=1024", n, ok);
    end
    checks++;
    if (pcm_out !== 16'h7FFF) begin
      failures++; $display("FAIL ones_pcm got=%h required=7fff", pcm_out);
    end
    @(negedge clk);
    checks++;
    if (pcm_valid !== 1'b0) begin
      failures++; $display("FAIL valid_width got=%b required=0", pcm_valid);
    end
    wait_valid(300, n, ok);
    checks++;
    if (!ok || n != 255) begin
      failures++; $display("FAIL valid_spacing got=%0d ok=%0d required=255", n, ok);
    end
  endtask

  task automatic test_zeros_alt();
    int   n;
    int   seen;
    bit   ok;
    logic prev;
    logic [15:0] last;
    pdm_in = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5 && ok; i++) wait_valid(300, n, ok);
    checks++;
    if (!ok || pcm_out !== 16'h8000) begin
      failures++; $display("FAIL zeros_pcm got=%h ok=%0d required=8000", pcm_out, ok);
    end
    seen = 0;
    n = 0;
    last = 16'hDEAD;
    prev = pdm_clk;
    while (seen < 6 && n < 6 * 256 + 64) begin
      @(negedge clk);
      n++;
      if (pcm_valid) begin
        seen++;
        last = pcm_out;
      end
      if (prev && !pdm_clk) pdm_in = ~pdm_in;
      prev = pdm_clk;
    end
    checks++;
    if (seen != 6 || last !== 16'h0000) begin
      failures++; $display("FAIL alt_pcm got=%h outputs=%0d required=0000", last, seen);
    end
  endtask

  task automatic test_overflow();
    int n;
    bit ok;
    logic [31:0] d;
    pdm_in = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 4 && ok; i++) wait_valid(300, n, ok);
    wait_valid(300, n, ok);
    cs = 1'b1; write = 1'b1; addr = 5'd1; wr_data = 32'd3;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0; wr_data = '0;
    rd(2'd1, d);
    checks++;
    if (!ok || d !== 32'd0) begin
      failures++; $display("FAIL flush_vs_push got=%h ok=%0d required=0", d, ok);
    end
    wait_valid(300, n, ok);
    pdm_in = 1'b1;
    for (int i = 0; i < 19 && ok; i++) wait_valid(300, n, ok);
    @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (!ok || d !== 32'd16) begin
      failures++; $display("FAIL ovf_count got=%0d ok=%0d required=16", d, ok);
    end
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0002_8000) begin
      failures++; $display("FAIL ovf_head got=%h required=%h", d, 32'h0002_8000);
    end
    for (int i = 0; i < 15; i++) wr(2'd0, 32'd0);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0002_7FFF) begin
      failures++; $display("FAIL last_head got=%h required=%h", d, 32'h0002_7FFF);
    end
    wr(2'd0, 32'd0);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0003_0000) begin
      failures++; $display("FAIL drained got=%h required=%h", d, 32'h0003_0000);
    end
    wr(2'd0, 32'd0);
    rd(2'd1, d);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL pop_empty got=%0d required=0", d);
    end
    wr(2'd1, 32'd3);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0001_0000) begin
      failures++; $display("FAIL flush_clears_ovf got=%h required=%h", d, 32'h0001_0000);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    logic [31:0] d;
    pdm_in = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 16 && ok; i++) wait_valid(300, n, ok);
    @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (!ok || d !== 32'd16) begin
      failures++; $display("FAIL full_count got=%0d ok=%0d required=16", d, ok);
    end
    wait_valid(300, n, ok);
    cs = 1'b1; write = 1'b1; addr = 5'd0; wr_data = '0;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0;
    rd(2'd1, d);
    checks++;
    if (!ok || d !== 32'd16) begin
      failures++; $display("FAIL push_pop_full_count got=%0d ok=%0d required=16", d, ok);
    end
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0000_7FFF) begin
      failures++; $display("FAIL push_pop_full_ovf got=%h required=%h", d, 32'h0000_7FFF);
    end
  endtask

  task automatic test_reset_mid();
    int   n;
    int   falls;
    bit   ok;
    logic prev;
    logic [31:0] d;
    wait_valid(300, n, ok);
    falls = 0;
    n = 0;
    prev = pdm_clk;
    while (falls < 30 && n < 400) begin
      @(negedge clk);
      n++;
      if (prev && !pdm_clk) falls++;
      prev = pdm_clk;
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (pdm_clk !== 1'b0 || pcm_valid !== 1'b0 || pcm_out !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset_outputs pdm_clk=%b valid=%b pcm=%h required 0/0/0000", pdm_clk, pcm_valid, pcm_out);
    end
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0001_0000) begin
      failures++; $display("FAIL async_reset_fifo got=%h required=%h", d, 32'h0001_0000);
    end
    rd(2'd3, d);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL async_reset_enable got=%h required=0", d);
    end
    @(negedge clk);
    reset = 1'b1;
    wr(2'd2, 32'd1);
    wr(2'd1, 32'd1);
    wait_valid(1100, n, ok);
    checks++;
    if (!ok || n != 1024 || pcm_out !== 16'h7FFF) begin
      failures++; $display("FAIL post_reset_first got=%0d pcm=%h ok=%0d required=1024/7fff", n, pcm_out, ok);
    end
    @(posedge clk);
    #1;
    rd(2'd1, d);
    checks++;
    if (d !== 32'd1) begin
      failures++; $display("FAIL post_reset_count got=%0d required=1", d);
    end
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0000_7FFF) begin
      failures++; $display("FAIL post_reset_head got=%h required=%h", d, 32'h0000_7FFF);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_divider();
    test_ones();
    test_zeros_alt();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
